// File: rtl/bcd_display_scan.sv
// Scans a shadowed bank of BCD digits onto one 7-segment bus with a one-hot
// digit enable, refresh prescaler, leading-zero blanking and frame-done pulse.
module bcd_display_scan #(
  parameter int NUM_DIGITS    = 4,
  parameter int SCAN_DIV      = 4,
  parameter int BLANK_LEADING = 1,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  input  logic                    scan_en,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        scan_idx,
  output logic                    frame_done
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] shadow;
  logic [PRE_W-1:0]        prescale;
  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [6:0]              seg_next;
  logic [3:0]              cur_digit;

  // Segment order {g,f,e,d,c,b,a}; any non-BCD code shows a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  // A digit is blank when it and every more-significant digit are zero;
  // digit 0 is never blanked so an all-zero value still reads "0".
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    logic zero_above;
    zero_above = 1'b1;
    blank      = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && (shadow[4*i +: 4] == 4'd0);
      blank[i]   = (BLANK_LEADING != 0) && zero_above;
    end
  end

  always_comb begin
    an_next           = '0;
    an_next[scan_idx] = 1'b1;
    cur_digit         = shadow[4*scan_idx +: 4];
    seg_next          = blank[scan_idx] ? 7'h00 : decode(cur_digit);
  end

  // NOTE: non-blocking assignments make a coincident load land after seg has
  // sampled the old shadow, which is exactly the tear-free behaviour wanted.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      shadow     <= '0;
      prescale   <= '0;
      scan_idx   <= '0;
      seg        <= '0;
      an         <= '0;
      frame_done <= 1'b0;
    end else begin
      if (load) begin
        shadow <= digits_in;
      end
      if (scan_en) begin
        an  <= an_next;
        seg <= seg_next;
        if (prescale == PRE_LAST) begin
          prescale   <= '0;
          scan_idx   <= (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
          frame_done <= (scan_idx == LAST_IDX);
        end else begin
          prescale   <= prescale + 1'b1;
          frame_done <= 1'b0;
        end
      end else begin
        // Display goes dark; prescale and index hold so scanning resumes in place.
        an         <= '0;
        seg        <= '0;
        frame_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Self-checking bench for bcd_display_scan: directed scenarios plus random
// load/enable traffic, all compared against a count-based behavioural model.
module tb_bcd_display_scan;

  localparam int N = 4;
  localparam int D = 4;
  localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic           CLK;
  logic           reset;
  logic [4*N-1:0] digits_in;
  logic           load;
  logic           scan_en;
  logic [6:0]     seg;
  logic [N-1:0]   an;
  logic [1:0]     scan_idx;
  logic           frame_done;

  int n_checks = 0;
  int n_errors = 0;

  // Model: m_cnt counts enabled edges since reset; the shown digit and the
  // frame position follow from it by plain division.
  int             m_cnt;
  logic [4*N-1:0] m_shadow;
  logic [N-1:0]   m_an;
  logic [6:0]     m_seg;
  logic [1:0]     m_idx;
  logic           m_fd;

  bcd_display_scan #(.NUM_DIGITS(N), .SCAN_DIV(D), .BLANK_LEADING(1)) dut (
    .CLK(CLK), .reset(reset), .digits_in(digits_in), .load(load),
    .scan_en(scan_en), .seg(seg), .an(an), .scan_idx(scan_idx),
    .frame_done(frame_done)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [6:0] model_seg(input logic [4*N-1:0] val, input int pos);
    int hi = 0;
    int d;
    for (int k = 0; k < N; k++) if (val[4*k +: 4] != 4'd0) hi = k;
    d = int'(val[4*pos +: 4]);
    if (pos > hi) return 7'h00;
    return (d > 9) ? 7'h40 : SEG_TAB[d];
  endfunction

  function automatic logic [13:0] exp_vec();
    return {m_an, m_seg, m_idx, m_fd};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_shadow = '0; m_an = '0; m_seg = '0; m_idx = '0; m_fd = 1'b0;
  endtask

  // One clock edge: advance the model with the inputs present at the edge,
  // then settle 1 time unit so outputs are sampled away from the edge.
  task automatic tick();
    int pos;
    @(posedge CLK);
    if (!reset) begin
      model_reset();
    end else begin
      if (scan_en) begin
        pos   = (m_cnt / D) % N;
        m_an  = N'(1 << pos);
        m_seg = model_seg(m_shadow, pos);
        m_cnt++;
        m_fd  = (m_cnt % (N * D)) == 0;
      end else begin
        m_an = '0; m_seg = '0; m_fd = 1'b0;
      end
      if (load) m_shadow = digits_in;
    end
    m_idx = 2'((m_cnt / D) % N);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; load = 1'b0; scan_en = 1'b0; digits_in = 16'h9876;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      load = ~load; scan_en = ~scan_en;
      tick();
      n_checks++;
      if ({an, seg, scan_idx, frame_done} !== exp_vec()) begin
        n_errors++;
        $display("FAIL reset_hold: got %h want %h", {an, seg, scan_idx, frame_done}, exp_vec());
      end
    end
    reset = 1'b1; load = 1'b0; scan_en = 1'b1;
    tick();
    n_checks++;
    if (an !== 4'b0001 || seg !== 7'h3F) begin
      n_errors++;
      $display("FAIL reset_release: got an=%b seg=%h want an=0001 seg=3f", an, seg);
    end
  endtask

  task automatic test_scan();
    int pulses = 0;
    digits_in = 16'h1234; load = 1'b1; scan_en = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4 * N * D; i++) begin
      tick();
      if (frame_done) pulses++;
      n_checks++;
      if ({an, seg, scan_idx, frame_done} !== exp_vec()) begin
        n_errors++;
        $display("FAIL scan_1234: got %h want %h", {an, seg, scan_idx, frame_done}, exp_vec());
      end
      if (an == 4'b1000) begin
        n_checks++;
        if (seg !== 7'h06) begin
          n_errors++;
          $display("FAIL scan_digit3: got seg=%h want 06", seg);
        end
      end
    end
    n_checks++;
    if (pulses != 4) begin
      n_errors++;
      $display("FAIL frame_done_count: got %0d want 4", pulses);
    end
  endtask

  task automatic run_value(input logic [4*N-1:0] val, input string name);
    digits_in = val; load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 2 * N * D; i++) begin
      tick();
      n_checks++;
      if ({an, seg, scan_idx, frame_done} !== exp_vec()) begin
        n_errors++;
        $display("FAIL %s: got %h want %h", name, {an, seg, scan_idx, frame_done}, exp_vec());
      end
    end
  endtask

  task automatic test_blanking();
    run_value(16'h0070, "blank_0070");
    run_value(16'h0000, "blank_0000");
    run_value(16'h0A05, "invalid_0a05");
    // Independent spot check of the dash and the non-blanked inner zero.
    for (int i = 0; i < N * D; i++) begin
      tick();
      if (an == 4'b0100 || an == 4'b0010) begin
        n_checks++;
        if (seg !== ((an == 4'b0100) ? 7'h40 : 7'h3F)) begin
          n_errors++;
          $display("FAIL dash_digit: an=%b got seg=%h", an, seg);
        end
      end
    end
  endtask

  task automatic test_freeze();
    bit found = 0;
    digits_in = 16'h5678; load = 1'b1;
    tick();
    load = 1'b0;
    // Stop with the index on digit 2 and one cycle of its slot consumed.
    for (int i = 0; i < 4 * N * D && !found; i++) begin
      if (m_cnt % (N * D) == 2 * D + 1) found = 1;
      else tick();
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL freeze_reach: got no idx2/pre1 point want one within budget");
    end
    scan_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({an, seg, scan_idx, frame_done} !== exp_vec() || scan_idx !== 2'd2) begin
        n_errors++;
        $display("FAIL freeze_hold: got %h want %h", {an, seg, scan_idx, frame_done}, exp_vec());
      end
    end
    scan_en = 1'b1;
    for (int i = 0; i < 3 * D; i++) begin
      tick();
      n_checks++;
      if ({an, seg, scan_idx, frame_done} !== exp_vec()) begin
        n_errors++;
        $display("FAIL freeze_resume: got %h want %h", {an, seg, scan_idx, frame_done}, exp_vec());
      end
      if (i < 3) begin
        n_checks++;
        if (an !== 4'b0100) begin
          n_errors++;
          $display("FAIL resume_digit2: cycle %0d got an=%b want 0100", i, an);
        end
      end
    end
  endtask

  task automatic test_midframe_reset();
    digits_in = 16'h4321; load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < N * D && m_idx != 2'd3; i++) tick();
    tick();
    reset = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({an, seg, scan_idx, frame_done} !== 14'h0) begin
      n_errors++;
      $display("FAIL async_reset: got %h want 0", {an, seg, scan_idx, frame_done});
    end
    tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if (an !== 4'b0001 || seg !== 7'h3F) begin
      n_errors++;
      $display("FAIL restart: got an=%b seg=%h want an=0001 seg=3f", an, seg);
    end
    for (int i = 0; i < N * D; i++) begin
      tick();
      n_checks++;
      if ({an, seg, scan_idx, frame_done} !== exp_vec()) begin
        n_errors++;
        $display("FAIL post_reset: got %h want %h", {an, seg, scan_idx, frame_done}, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      load    = ($urandom_range(0, 7) == 0);
      scan_en = ($urandom_range(0, 9) != 0);
      for (int k = 0; k < N; k++)
        digits_in[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      tick();
      n_checks++;
      if ({an, seg, scan_idx, frame_done} !== exp_vec()) begin
        n_errors++;
        $display("FAIL random: cycle %0d got %h want %h", i, {an, seg, scan_idx, frame_done}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blanking();
    test_freeze();
    test_midframe_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
